// File: rtl/mac_accumulate_stage_if.sv
// Handshake/bus bundle for mac_accumulate_stage.
// Input side:  in_valid/in_ready carry one (in_a, in_b, in_last) operand pair.
// Output side: out_valid/out_ready carry one group result (out_acc, out_count, out_ovf).
// Both handshakes follow the same valid/ready rule:
//   - A transfer happens on a rising clk edge where valid && ready.
//   - Once valid is high, the producer holds valid and its payload stable until that transfer.
//   - ready may depend combinationally on state, but never on valid of the same channel.
interface mac_accumulate_stage_if #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_a;
   logic [7:0]       in_b;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_acc;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   // The stage itself.
   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_count, out_ovf
   );

   // Whoever feeds operands and consumes results.
   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_count, out_ovf
   );
endinterface

// File: rtl/mac_accumulate_stage.sv
// mac_accumulate_stage: three-stage multiply-accumulate around an 8x8 unsigned multiplier.
//   S1 registers the operands, S2 registers the 16-bit product, and S3 accumulates
//   each last-delimited group into the output register.
// Optional feature macro: MAC_SATURATE_EN.
//   Defined:   the accumulator clamps to all-ones on carry-out.
//   Undefined: the accumulator wraps modulo 2^ACC_W.
// out_ovf is set on carry-out in both builds.
module mac_accumulate_stage #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
) (
   input logic                     clk,
   input logic                     rst_n,
   mac_accumulate_stage_if.slave   bus
);

   // S1: operand registers
   logic             r_s1_valid;
   logic [7:0]       r_s1_a;
   logic [7:0]       r_s1_b;
   logic             r_s1_last;

   // S2: product registers
   logic             r_s2_valid;
   logic [15:0]      r_s2_prod;
   logic             r_s2_last;

   // S3: running group state
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic             r_group_start;

   // S3: output registers
   logic             r_out_valid;
   logic [ACC_W-1:0] r_out_acc;
   logic [CNT_W-1:0] r_out_count;
   logic             r_out_ovf;

   logic             w_stall;
   logic             w_accept;
   logic             w_s2_fire;
   logic [15:0]      w_prod;
   logic [ACC_W-1:0] w_acc_base;
   logic [CNT_W-1:0] w_cnt_base;
   logic [ACC_W:0]   w_sum;
   logic             w_carry;
   logic             w_ovf_next;
   logic [ACC_W-1:0] w_acc_next;
   logic [CNT_W-1:0] w_cnt_next;

   // Only a finishing beat needs the output register.
   // Non-last beats keep flowing while a result waits.
   assign w_stall   = r_out_valid && !bus.out_ready && r_s2_valid && r_s2_last;
   assign w_accept  = bus.in_valid && !w_stall;
   assign w_s2_fire = r_s2_valid && !w_stall;

   // The multiplier is zero-extended to 16 bits so the full product is kept.
   assign w_prod = {8'd0, r_s1_a} * {8'd0, r_s1_b};

   // Next accumulator, count and overflow if the S2 beat is consumed this cycle.
   always_comb begin
      w_acc_base = r_group_start ? '0 : r_acc;
      w_cnt_base = r_group_start ? '0 : r_cnt;
      w_sum      = {1'b0, w_acc_base} + {{(ACC_W + 1 - 16){1'b0}}, r_s2_prod};
      w_carry    = w_sum[ACC_W];
      w_ovf_next = (r_group_start ? 1'b0 : r_ovf) | w_carry;
`ifdef MAC_SATURATE_EN
      // Once the group has overflowed, it stays pinned at full scale.
      w_acc_next = w_ovf_next ? '1 : w_sum[ACC_W-1:0];
`else
      w_acc_next = w_sum[ACC_W-1:0];
`endif
      w_cnt_next = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);
   end

   // S1/S2 pipeline advance; both stages freeze together while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_last  <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2_prod  <= '0;
         r_s2_last  <= 1'b0;
      end else if (!w_stall) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_a    <= bus.in_a;
            r_s1_b    <= bus.in_b;
            r_s1_last <= bus.in_last;
         end
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_prod <= w_prod;
            r_s2_last <= r_s1_last;
         end
      end
   end

   // Group accumulator: fold in each consumed S2 beat, clear after the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc         <= '0;
         r_cnt         <= '0;
         r_ovf         <= 1'b0;
         r_group_start <= 1'b1;
      end else if (w_s2_fire) begin
         if (r_s2_last) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_ovf         <= 1'b0;
            r_group_start <= 1'b1;
         end else begin
            r_acc         <= w_acc_next;
            r_cnt         <= w_cnt_next;
            r_ovf         <= w_ovf_next;
            r_group_start <= 1'b0;
         end
      end
   end

   // Output register: load on a finishing beat, otherwise drop valid once taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_acc   <= '0;
         r_out_count <= '0;
         r_out_ovf   <= 1'b0;
      end else if (w_s2_fire && r_s2_last) begin
         r_out_valid <= 1'b1;
         r_out_acc   <= w_acc_next;
         r_out_count <= w_cnt_next;
         r_out_ovf   <= w_ovf_next;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = !w_stall;
   assign bus.out_valid = r_out_valid;
   assign bus.out_acc   = r_out_acc;
   assign bus.out_count = r_out_count;
   assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Directed testbench for mac_accumulate_stage.
// Two instances are used: ACC_W=24 for the main scenarios, and ACC_W=16 for overflow.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mac_accumulate_stage;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   mac_accumulate_stage_if #(.ACC_W(24), .CNT_W(8)) bi();
   mac_accumulate_stage_if #(.ACC_W(16), .CNT_W(8)) bs();

   mac_accumulate_stage #(.ACC_W(24), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bi)
   );

   mac_accumulate_stage #(.ACC_W(16), .CNT_W(8)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bs)
   );

   // clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle24();
      bi.in_valid = 1'b0;
      bi.in_last  = 1'b0;
   endtask

   task automatic idle16();
      bs.in_valid = 1'b0;
      bs.in_last  = 1'b0;
   endtask

   // Offer one pair and return just after the edge that accepted it.
   // in_valid is left high; the caller drops it with idle24().
   task automatic send24(input logic [7:0] a, input logic [7:0] b, input logic last);
      bit done;
      done = 0;
      bi.in_valid = 1'b1;
      bi.in_a     = a;
      bi.in_b     = b;
      bi.in_last  = last;
      for (int i = 0; i < 50; i++) begin
         if (bi.in_ready) begin
            tick();
            done = 1;
            break;
         end
         tick();
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send24_accept: in_ready never high, got 0 required 1");
      end
   endtask

   task automatic send16(input logic [7:0] a, input logic [7:0] b, input logic last);
      bit done;
      done = 0;
      bs.in_valid = 1'b1;
      bs.in_a     = a;
      bs.in_b     = b;
      bs.in_last  = last;
      for (int i = 0; i < 50; i++) begin
         if (bs.in_ready) begin
            tick();
            done = 1;
            break;
         end
         tick();
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send16_accept: in_ready never high, got 0 required 1");
      end
   endtask

   task automatic wait_out24(output bit ok);
      for (int i = 0; i < 20; i++) begin
         if (bi.out_valid) break;
         tick();
      end
      ok = bi.out_valid;
   endtask

   task automatic wait_out16(output bit ok);
      for (int i = 0; i < 20; i++) begin
         if (bs.out_valid) break;
         tick();
      end
      ok = bs.out_valid;
   endtask

   task automatic consume24();
      bi.out_ready = 1'b1;
      tick();
      bi.out_ready = 1'b0;
   endtask

   task automatic consume16();
      bs.out_ready = 1'b1;
      tick();
      bs.out_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      idle24();
      idle16();
      bi.in_a = 0; bi.in_b = 0; bi.out_ready = 0;
      bs.in_a = 0; bs.in_b = 0; bs.out_ready = 0;
      tick(); tick();
      checks++; if (bi.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", bi.out_valid); end
      checks++; if (bi.out_acc !== 24'd0) begin errors++; $display("FAIL reset_out_acc: got %0d required 0", bi.out_acc); end
      checks++; if (bi.out_count !== 8'd0) begin errors++; $display("FAIL reset_out_count: got %0d required 0", bi.out_count); end
      checks++; if (bi.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %0b required 0", bi.out_ovf); end
      checks++; if (bi.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", bi.in_ready); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_latency();
      send24(8'd255, 8'd255, 1'b1);
      idle24();
      checks++; if (bi.out_valid !== 1'b0) begin errors++; $display("FAIL single_lat_k: got %0b required 0", bi.out_valid); end
      tick();
      checks++; if (bi.out_valid !== 1'b0) begin errors++; $display("FAIL single_lat_k1: got %0b required 0", bi.out_valid); end
      tick();
      checks++; if (bi.out_valid !== 1'b1) begin errors++; $display("FAIL single_lat_k2: got %0b required 1", bi.out_valid); end
      checks++; if (bi.out_acc !== 24'd65025) begin errors++; $display("FAIL single_acc: got %0d required 65025", bi.out_acc); end
      checks++; if (bi.out_count !== 8'd1) begin errors++; $display("FAIL single_count: got %0d required 1", bi.out_count); end
      checks++; if (bi.out_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf: got %0b required 0", bi.out_ovf); end
      consume24();
      checks++; if (bi.out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_clear: got %0b required 0", bi.out_valid); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      send24(8'd1, 8'd2, 1'b0);
      send24(8'd3, 8'd4, 1'b0);
      send24(8'd5, 8'd6, 1'b0);
      send24(8'd7, 8'd8, 1'b1);
      idle24();
      wait_out24(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: out_valid got 0 required 1"); end
      checks++; if (bi.out_acc !== 24'd100) begin errors++; $display("FAIL b2b_acc: got %0d required 100", bi.out_acc); end
      checks++; if (bi.out_count !== 8'd4) begin errors++; $display("FAIL b2b_count: got %0d required 4", bi.out_count); end
      checks++; if (bi.out_ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %0b required 0", bi.out_ovf); end
      consume24();
   endtask

   task automatic test_overflow16();
      bit ok;
      logic [15:0] exp_acc;
`ifdef MAC_SATURATE_EN
      exp_acc = 16'd65535;
`else
      exp_acc = 16'd64514;
`endif
      send16(8'd255, 8'd255, 1'b0);
      send16(8'd255, 8'd255, 1'b1);
      idle16();
      wait_out16(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ovf16_timeout: out_valid got 0 required 1"); end
      checks++; if (bs.out_acc !== exp_acc) begin errors++; $display("FAIL ovf16_acc: got %0d required %0d", bs.out_acc, exp_acc); end
      checks++; if (bs.out_ovf !== 1'b1) begin errors++; $display("FAIL ovf16_flag: got %0b required 1", bs.out_ovf); end
      checks++; if (bs.out_count !== 8'd2) begin errors++; $display("FAIL ovf16_count: got %0d required 2", bs.out_count); end
      consume16();
      // The next group must start clean.
      send16(8'd1, 8'd1, 1'b1);
      idle16();
      wait_out16(ok);
      checks++; if (bs.out_acc !== 16'd1) begin errors++; $display("FAIL ovf16_next_acc: got %0d required 1", bs.out_acc); end
      checks++; if (bs.out_ovf !== 1'b0) begin errors++; $display("FAIL ovf16_next_ovf: got %0b required 0", bs.out_ovf); end
      consume16();
   endtask

   task automatic test_backpressure();
      bi.out_ready = 1'b0;
      send24(8'd2, 8'd3, 1'b1);
      send24(8'd4, 8'd5, 1'b1);
      idle24();
      tick();
      checks++; if (bi.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid1: got %0b required 1", bi.out_valid); end
      checks++; if (bi.out_acc !== 24'd6) begin errors++; $display("FAIL bp_acc1: got %0d required 6", bi.out_acc); end
      checks++; if (bi.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %0b required 0", bi.in_ready); end
      tick(); tick();
      checks++; if (bi.out_acc !== 24'd6) begin errors++; $display("FAIL bp_acc1_hold: got %0d required 6", bi.out_acc); end
      checks++; if (bi.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_hold: got %0b required 0", bi.in_ready); end
      bi.out_ready = 1'b1;
      #1;
      checks++; if (bi.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release: got %0b required 1", bi.in_ready); end
      tick();
      checks++; if (bi.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid2: got %0b required 1", bi.out_valid); end
      checks++; if (bi.out_acc !== 24'd20) begin errors++; $display("FAIL bp_acc2: got %0d required 20", bi.out_acc); end
      checks++; if (bi.out_count !== 8'd1) begin errors++; $display("FAIL bp_count2: got %0d required 1", bi.out_count); end
      tick();
      checks++; if (bi.out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_clear: got %0b required 0", bi.out_valid); end
      bi.out_ready = 1'b0;
   endtask

   task automatic test_bubbles();
      bit ok;
      send24(8'd10, 8'd10, 1'b0);
      idle24();
      tick();
      send24(8'd10, 8'd10, 1'b0);
      idle24();
      tick();
      send24(8'd10, 8'd10, 1'b1);
      idle24();
      wait_out24(ok);
      checks++; if (!ok) begin errors++; $display("FAIL bubble_timeout: out_valid got 0 required 1"); end
      checks++; if (bi.out_acc !== 24'd300) begin errors++; $display("FAIL bubble_acc: got %0d required 300", bi.out_acc); end
      checks++; if (bi.out_count !== 8'd3) begin errors++; $display("FAIL bubble_count: got %0d required 3", bi.out_count); end
      consume24();
   endtask

   task automatic test_reset_mid_group();
      bit ok;
      send24(8'd2, 8'd2, 1'b1);
      idle24();
      wait_out24(ok);
      checks++; if (bi.out_acc !== 24'd4) begin errors++; $display("FAIL rmid_pending_acc: got %0d required 4", bi.out_acc); end
      send24(8'd3, 8'd3, 1'b0);
      send24(8'd4, 8'd4, 1'b0);
      idle24();
      #2;
      rst_n = 1'b0;
      #1;
      // No clock edge has occurred since the reset assertion.
      checks++; if (bi.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valid: got %0b required 0", bi.out_valid); end
      checks++; if (bi.out_acc !== 24'd0) begin errors++; $display("FAIL rmid_async_acc: got %0d required 0", bi.out_acc); end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      send24(8'd9, 8'd9, 1'b1);
      idle24();
      wait_out24(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout: out_valid got 0 required 1"); end
      checks++; if (bi.out_acc !== 24'd81) begin errors++; $display("FAIL rmid_acc: got %0d required 81", bi.out_acc); end
      checks++; if (bi.out_count !== 8'd1) begin errors++; $display("FAIL rmid_count: got %0d required 1", bi.out_count); end
      checks++; if (bi.out_ovf !== 1'b0) begin errors++; $display("FAIL rmid_ovf: got %0b required 0", bi.out_ovf); end
      consume24();
   endtask

   task automatic test_count_saturation();
      bit ok;
      for (int i = 0; i < 300; i++) begin
         send24(8'd1, 8'd1, (i == 299));
      end
      idle24();
      wait_out24(ok);
      checks++; if (!ok) begin errors++; $display("FAIL cnt_sat_timeout: out_valid got 0 required 1"); end
      checks++; if (bi.out_count !== 8'd255) begin errors++; $display("FAIL cnt_sat_count: got %0d required 255", bi.out_count); end
      checks++; if (bi.out_acc !== 24'd300) begin errors++; $display("FAIL cnt_sat_acc: got %0d required 300", bi.out_acc); end
      consume24();
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_single_latency();
      test_back_to_back();
      test_overflow16();
      test_backpressure();
      test_bubbles();
      test_reset_mid_group();
      test_count_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mac_accumulate_stage.md
Name: mac_accumulate_stage

Overview:
- Sequential stage wrapped around the team's combinational 8x8 unsigned array multiplier.
- Accepts a stream of (a, b) operand pairs over a valid/ready handshake and registers the 16-bit products.
- Accumulates each group of products, delimited by a last flag, into a wide sum.
- Presents one result per group (sum, term count, overflow flag) on a backpressured output handshake.

Parameters:
- ACC_W, 24, accumulator/result width in bits; must be >= 16.
- CNT_W, 8, term-counter width; the counter saturates at all-ones.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept an operand pair
- in_a  in  8  unsigned multiplicand
- in_b  in  8  unsigned multiplier
- in_last  in  1  final pair of the current group
- out_valid  out  1  group result valid
- out_ready  in  1  consumer accepts the result
- out_acc  out  ACC_W  group sum of products
- out_count  out  CNT_W  number of pairs in the group
- out_ovf  out  1  sticky overflow for the group

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all pipeline valids, the accumulator, the counter, out_valid, out_acc, out_count and out_ovf are 0. in_ready is 1 out of reset.
- Reset mid-group discards the partial sum and any pending output immediately, without waiting for a clock edge.
- Pipeline stages:
  - S1: registers a, b and last on accept (in_valid && in_ready).
  - S2: registers the 16-bit product of the S1 operands plus last.
  - S3: accumulator and output register.
- Stall condition: stall = out_valid && !out_ready && S2 holds a last beat. in_ready = !stall. On stall, S1 and S2 hold their contents.
- Accumulate rule: the product is zero-extended to ACC_W. The add is acc_sum = (group_start ? 0 : acc) + product, computed at ACC_W+1 bits.
- group_start is 1 after reset and after every last beat leaves S2.
- Term count: cnt increments per S2 beat and holds at 2^CNT_W-1 once reached.
- Overflow: a carry out of bit ACC_W-1 sets the sticky ovf flag for the group. With the macro undefined the sum wraps modulo 2^ACC_W.
- When a last beat leaves S2:
  - out_acc, out_count and out_ovf load the final values (including that beat) and out_valid goes to 1.
  - acc, cnt and ovf clear for the next group.
- Latency: a last pair accepted at edge k gives out_valid=1 after edge k+2. Sustained throughput is 1 pair/cycle.
- out_acc, out_count and out_ovf hold stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a new result loads in the same edge.
- Simultaneous out_ready and a new last in S2: the output registers take the new result and out_valid stays 1 (back-to-back results, no bubble).
- A single-pair group (in_last on the first pair) is legal; its count is 1.
- in_valid low inserts bubbles. Bubbles do not change acc or cnt.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined: when the add carries out, acc clamps to 2^ACC_W-1 and stays there for the rest of the group; ovf is still set.
- Undefined: the sum wraps modulo 2^ACC_W and ovf is set.
- The macro affects only the accumulate path; handshake and latency are identical either way.

Test Plan:
- Reset then a single pair a=255, b=255, last=1 -> after 2 cycles out_valid=1, out_acc=65025, out_count=1, out_ovf=0.
- Four pairs (1,2), (3,4), (5,6), (7,8) back-to-back with last on the fourth -> out_acc=100, out_count=4.
- ACC_W=16, pairs (255,255), (255,255), last -> without the macro out_acc=64514 (130050 mod 65536) and ovf=1; with MAC_SATURATE_EN out_acc=65535 and ovf=1.
- Two single-pair groups (2,3) and (4,5) with out_ready held low:
  - first result 6 holds and in_ready drops;
  - raise out_ready -> 6 is accepted, then 20 is presented;
  - no beats are lost.
- in_valid toggling every other cycle across 3 pairs (10,10) -> out_acc=300, out_count=3.
- Assert rst_n low mid-group after 2 pairs, release, then send (9,9) last -> out_acc=81, out_count=1.
